// File: rtl/rr_mux_reg_pkg.sv
// Shared constants and helpers for the registered round-robin multiplexer.
package rr_mux_reg_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Channel-index width; a single channel still needs one bit to encode.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// Producer-side channel bundle plus consumer-side output bus of rr_mux_reg.
interface rr_mux_reg_if #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int CW   = 2
);
    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_ready;
    logic              force_en;
    logic [CW-1:0]     force_sel;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [CW-1:0]     out_ch;
    logic              out_ready;

    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_arbiter.sv
// Picks one requesting channel: forced, or first valid at/after ptr with wrap.
// Also produces the pointer value to adopt if this grant is accepted.
module rr_arbiter
    import rr_mux_reg_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = MODE_RR,
    parameter int CW   = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] valid,
    input  logic [CW-1:0]   ptr,
    input  logic            force_en,
    input  logic [CW-1:0]   force_sel,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   grant_idx,
    output logic            grant_any,
    output logic [CW-1:0]   ptr_next
);
    logic [N_CH-1:0] force_hit;
    logic [N_CH-1:0] upper_valid;
    logic [N_CH-1:0] upper_first;
    logic [N_CH-1:0] any_first;
    logic [N_CH-1:0] search_grant;

    // An out-of-range force_sel matches no bit, so it yields no grant.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign force_hit[gi]   = (force_sel == CW'(gi));
            assign upper_valid[gi] = valid[gi] & (CW'(gi) >= ptr);
        end
    endgenerate

    // Isolate the lowest set bit; the upper half wins, otherwise wrap around.
    assign upper_first  = upper_valid & (~upper_valid + N_CH'(1));
    assign any_first    = valid & (~valid + N_CH'(1));
    assign search_grant = (|upper_valid) ? upper_first : any_first;

    assign grant     = force_en ? (valid & force_hit) : search_grant;
    assign grant_any = |grant;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) grant_idx = grant_idx | CW'(i);
        end
    end

    always_comb begin
        ptr_next = '0;
        if (MODE == MODE_RR && grant_idx != CW'(N_CH - 1)) ptr_next = grant_idx + CW'(1);
    end
endmodule

// File: rtl/rr_mux_reg.sv
// N-channel registered multiplexer: arbitration feeds a one-entry output
// register that can pop and reload in the same cycle.
module rr_mux_reg
    import rr_mux_reg_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_RR,
    parameter int CW   = clog2_min1(N_CH)
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_reg_if.slave bus
);
    logic            out_valid_reg;
    logic [W-1:0]    out_data_reg;
    logic [CW-1:0]   out_ch_reg;
    logic [CW-1:0]   ptr_reg;
    logic [CW-1:0]   ptr_next;
    logic [N_CH-1:0] grant;
    logic [CW-1:0]   grant_idx;
    logic            grant_any;
    logic            ld;
    logic            xfer;
    logic [W-1:0]    sel_data;

    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE),
        .CW   (CW)
    ) u_arb (
        .valid     (bus.in_valid),
        .ptr       (ptr_reg),
        .force_en  (bus.force_en),
        .force_sel (bus.force_sel),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any),
        .ptr_next  (ptr_next)
    );

    // Gating with rst_n keeps in_ready low for the whole reset pulse,
    // even though the empty register would otherwise accept.
    assign ld           = !out_valid_reg | bus.out_ready;
    assign xfer         = grant_any & ld & rst_n;
    assign bus.in_ready = grant & {N_CH{ld & rst_n}};

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) sel_data = sel_data | bus.in_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            ptr_reg       <= '0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sel_data;
            out_ch_reg    <= grant_idx;
            ptr_reg       <= ptr_next;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Drives three rr_mux_reg variants (4ch RR, 4ch fixed, 3ch RR) with shared
// stimulus and compares each against a cycle-level reference model.
module tb_rr_mux_reg;
    import rr_mux_reg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  s_valid = '0;
    logic [31:0] s_data  = '0;
    logic        s_fen   = 1'b0;
    logic [1:0]  s_fsel  = '0;
    logic        s_ordy  = 1'b0;

    rr_mux_reg_if #(.N_CH(4), .W(8), .CW(2)) if_a ();
    rr_mux_reg_if #(.N_CH(4), .W(8), .CW(2)) if_b ();
    rr_mux_reg_if #(.N_CH(3), .W(8), .CW(2)) if_c ();

    assign if_a.in_valid  = s_valid;
    assign if_a.in_data   = s_data;
    assign if_a.force_en  = s_fen;
    assign if_a.force_sel = s_fsel;
    assign if_a.out_ready = s_ordy;
    assign if_b.in_valid  = s_valid;
    assign if_b.in_data   = s_data;
    assign if_b.force_en  = s_fen;
    assign if_b.force_sel = s_fsel;
    assign if_b.out_ready = s_ordy;
    assign if_c.in_valid  = s_valid[2:0];
    assign if_c.in_data   = s_data[23:0];
    assign if_c.force_en  = s_fen;
    assign if_c.force_sel = s_fsel;
    assign if_c.out_ready = s_ordy;

    rr_mux_reg #(.N_CH(4), .W(8), .MODE(MODE_RR), .CW(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    rr_mux_reg #(.N_CH(4), .W(8), .MODE(MODE_FIXED), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    rr_mux_reg #(.N_CH(3), .W(8), .MODE(MODE_RR), .CW(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c));

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per instance: 0 = 4ch RR, 1 = 4ch fixed, 2 = 3ch RR.
    int m_n[3]    = '{4, 4, 3};
    int m_mode[3] = '{1, 0, 1};
    int m_valid[3];
    int m_data[3];
    int m_ch[3];
    int m_ptr[3];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int obs_rdy(input int k);
        case (k)
            0:       return int'(if_a.in_ready);
            1:       return int'(if_b.in_ready);
            default: return int'(if_c.in_ready);
        endcase
    endfunction

    function automatic int obs_valid(input int k);
        case (k)
            0:       return int'(if_a.out_valid);
            1:       return int'(if_b.out_valid);
            default: return int'(if_c.out_valid);
        endcase
    endfunction

    function automatic int obs_data(input int k);
        case (k)
            0:       return int'(if_a.out_data);
            1:       return int'(if_b.out_data);
            default: return int'(if_c.out_data);
        endcase
    endfunction

    function automatic int obs_ch(input int k);
        case (k)
            0:       return int'(if_a.out_ch);
            1:       return int'(if_b.out_ch);
            default: return int'(if_c.out_ch);
        endcase
    endfunction

    // Granted channel under the current inputs, or -1 for none.
    function automatic int model_grant(input int k);
        int n;
        int idx;
        n = m_n[k];
        if (s_fen) begin
            if (int'(s_fsel) < n && s_valid[s_fsel]) return int'(s_fsel);
            return -1;
        end
        for (int j = 0; j < n; j++) begin
            idx = (m_mode[k] == 1) ? (m_ptr[k] + j) % n : j;
            if (s_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0;
            m_data[k]  = 0;
            m_ch[k]    = 0;
            m_ptr[k]   = 0;
        end
    endtask

    // One clock cycle with the current inputs: check in_ready before the
    // edge, advance the model, check the registered outputs after it.
    task automatic step(input string tag);
        int g;
        bit ld;
        int nv[3];
        int nd[3];
        int nc[3];
        int np[3];
        #2;
        for (int k = 0; k < 3; k++) begin
            g  = model_grant(k);
            ld = (m_valid[k] == 0) || s_ordy;
            chk($sformatf("%s[%0d].in_ready", tag, k), obs_rdy(k),
                (g >= 0 && ld) ? (1 << g) : 0);
            nv[k] = m_valid[k];
            nd[k] = m_data[k];
            nc[k] = m_ch[k];
            np[k] = m_ptr[k];
            if (g >= 0 && ld) begin
                nv[k] = 1;
                nd[k] = int'(s_data[g*8 +: 8]);
                nc[k] = g;
                if (m_mode[k] == 1) np[k] = (g + 1) % m_n[k];
            end else if (s_ordy) begin
                nv[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = nv[k];
            m_data[k]  = nd[k];
            m_ch[k]    = nc[k];
            m_ptr[k]   = np[k];
            chk($sformatf("%s[%0d].out_valid", tag, k), obs_valid(k), m_valid[k]);
            chk($sformatf("%s[%0d].out_data", tag, k), obs_data(k), m_data[k]);
            chk($sformatf("%s[%0d].out_ch", tag, k), obs_ch(k), m_ch[k]);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s[%0d].out_valid", tag, k), obs_valid(k), 0);
            chk($sformatf("%s[%0d].out_data", tag, k), obs_data(k), 0);
            chk($sformatf("%s[%0d].out_ch", tag, k), obs_ch(k), 0);
            chk($sformatf("%s[%0d].in_ready", tag, k), obs_rdy(k), 0);
        end
    endtask

    initial begin
        int held_data;
        int held_ch;
        model_reset();
        s_valid = 4'hF;
        s_data  = 32'h44332211;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;

        // All channels valid, consumer always ready: 0,1,2,3,0 on the RR instance.
        s_data = 32'hA3A2A1A0;
        s_ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("fair");
            chk("fair.a.out_ch", int'(if_a.out_ch), i % 4);
            chk("fair.a.out_data", int'(if_a.out_data), 8'hA0 + (i % 4));
        end

        // Stall with a held word, then release: pop and reload together.
        s_ordy    = 1'b0;
        held_data = int'(if_a.out_data);
        held_ch   = int'(if_a.out_ch);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.a.out_data", int'(if_a.out_data), held_data);
            chk("stall.a.out_ch", int'(if_a.out_ch), held_ch);
        end
        s_ordy = 1'b1;
        step("release");
        chk("release.a.out_valid", int'(if_a.out_valid), 1);
        chk("release.a.out_ch", int'(if_a.out_ch), (held_ch + 1) % 4);

        // Forced select 2 wins every cycle despite all channels requesting.
        s_fen  = 1'b1;
        s_fsel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step("force2");
            chk("force2.a.out_ch", int'(if_a.out_ch), 2);
            chk("force2.c.out_ch", int'(if_c.out_ch), 2);
        end

        // Force index beyond the 3-channel instance: nothing granted there.
        s_fsel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("force3.c.in_ready", int'(if_c.in_ready), 0);
            step("force3");
            chk("force3.c.out_valid", int'(if_c.out_valid), 0);
        end

        // Fixed priority: ch1 until it drops, then ch3.
        s_fen   = 1'b0;
        s_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step("fixed");
            chk("fixed.b.out_ch", int'(if_b.out_ch), 1);
        end
        s_valid = 4'b1000;
        step("fixed");
        chk("fixed.b.out_ch", int'(if_b.out_ch), 3);

        // Park the RR pointer at 3 via a forced ch2 transfer, then wrap.
        s_fen   = 1'b1;
        s_fsel  = 2'd2;
        s_valid = 4'hF;
        step("wrapset");
        s_fen   = 1'b0;
        s_valid = 4'b0101;
        step("wrap");
        chk("wrap.a.out_ch", int'(if_a.out_ch), 0);
        step("wrap");
        chk("wrap.a.out_ch", int'(if_a.out_ch), 2);

        for (int i = 0; i < 300; i++) begin
            s_valid = 4'($urandom);
            s_data  = $urandom;
            s_fen   = ($urandom_range(0, 3) == 0);
            s_fsel  = 2'($urandom);
            s_ordy  = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // Asynchronous reset in the middle of a cycle with a word held.
        s_fen   = 1'b0;
        s_valid = 4'hF;
        s_ordy  = 1'b0;
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_state("rst_hold");
        rst_n  = 1'b1;
        s_ordy = 1'b1;
        s_data = 32'hB3B2B1B0;
        step("post_rst");
        chk("post_rst.a.out_ch", int'(if_a.out_ch), 0);
        step("post_rst");
        chk("post_rst.a.out_ch", int'(if_a.out_ch), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
